gshare_tagged_branch_predictor: RTL and testbench
=================================================

// Module: gshare_tagged_branch_predictor
// PURPOSE
//  Parametrised dynamic branch predictor for the IF stage.
//  - Direction: table of CTR_W-bit saturating counters, indexed bimodally or gshare (PC xor global history).
//  - Target: tagged, valid-qualified BTB.
//  - Lookup is combinational on fetch_pc. Resolution from decode trains both tables.
//  - Also keeps the global history register (GHR) and performance counters.
// PARAMETERS
//  ENTRIES  16  entries per table; power of 2, >=2; IDX_W = $clog2(ENTRIES)
//  ADDR_W   16  PC/target width
//  CTR_W    2   saturating counter width, >=2
//  GHR_W    4   global history length, 1..IDX_W
//  GSHARE   1   1: index = pc[IDX_W:1] ^ zero-ext(ghr); 0: index = pc[IDX_W:1]
//  TAG_W    4   BTB tag = pc[IDX_W+TAG_W:IDX_W+1]; IDX_W+TAG_W+1 <= ADDR_W
//  PERF_W   16  performance counter width
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  enable         in   1       0 = hold all state, lookup outputs forced 0
//  fetch_pc       in   ADDR_W  PC being fetched
//  pred_taken     out  1       predicted taken
//  pred_target    out  ADDR_W  predicted target (0 unless pred_taken)
//  pred_btb_hit   out  1       BTB valid & tag match for fetch_pc
//  pred_ghr       out  GHR_W   GHR used for this lookup; pipelined to decode by the caller
//  upd_valid      in   1       resolved branch this cycle
//  upd_pc         in   ADDR_W  PC of resolved branch
//  upd_ghr        in   GHR_W   pred_ghr captured when that branch was fetched
//  upd_taken      in   1       actual direction
//  upd_target     in   ADDR_W  actual target
//  upd_mispredict in   1       direction or target mispredicted
//  perf_branches  out  PERF_W  resolved branch count, saturating
//  perf_mispred   out  PERF_W  misprediction count, saturating
// BEHAVIOUR
//  Reset (rst high at posedge), takes effect next edge:
//  - all counters = WNT = 2^(CTR_W-1)-1; all BTB valid=0, tag=0, target=0
//  - GHR=0; perf counters=0
//  - while rst is high, all lookup outputs are 0
//  - rst mid-operation wins over any same-cycle update
//  Lookup (0-cycle, combinational):
//  - l_idx = GSHARE ? pc[IDX_W:1]^ghr : pc[IDX_W:1]; PC bit 0 is ignored
//  - pred_btb_hit = enable & valid[b_idx] & (tag[b_idx]==fetch_pc tag); b_idx = pc[IDX_W:1], never hashed
//  - pred_taken = pred_btb_hit & ctr[l_idx][CTR_W-1]; no target means no taken prediction
//  - pred_target = pred_taken ? target[b_idx] : 0; pred_ghr = enable ? ghr : 0
//  Update (enable & upd_valid, written at posedge):
//  - Counter at u_idx (upd_pc with upd_ghr): +1 if taken, -1 if not; saturates at 0 and 2^CTR_W-1.
//    Trains on every resolved branch, not only on mispredicts.
//  - BTB: if upd_taken, write valid=1, tag, target at upd_pc's b_idx, replacing any alias.
//    Not-taken leaves the BTB unchanged.
//  - GHR <= {ghr[GHR_W-2:0], upd_taken} (for GHR_W=1, ghr <= upd_taken).
//    Non-speculative: GHR advances only on resolution.
//  - perf_branches += 1; perf_mispred += upd_mispredict; both saturate at all-ones.
//  - upd_* ignored when enable=0 or upd_valid=0.
//  Simultaneous lookup and update to the same entry: lookup returns the pre-update value (no bypass).
//  One update per cycle maximum; no back-pressure; no X on outputs after reset.
// STRUCTURE
//  - Package bp_pkg:
//    - function sat_ctr_next(ctr, taken, CTR_W)
//    - localparam helpers for idx/tag slicing
//    - typedef btb_entry_t {valid, tag, target}
//  - Storage: flop arrays (ENTRIES is small), synchronous reset.
//  - One sub-module: bp_perf_counter (saturating PERF_W counter with inc input), instantiated twice.
// TESTING
//  1 Reset, fetch_pc=0x0004 -> pred_taken=0, pred_target=0, pred_btb_hit=0, perf_*=0; ctr dump = all 1.
//  2 GSHARE=0: resolve pc=0x0006 taken, target=0x0040, twice ->
//    ctr[3]=3, lookup 0x0006 gives taken, target 0x0040, hit.
//    Then one not-taken -> ctr[3]=2, still taken.
//  3 BTB alias: train 0x0006 taken->0x0040, then 0x0026 taken->0x0080 ->
//    lookup 0x0006 misses (hit=0, taken=0); lookup 0x0026 hits 0x0080.
//  4 GSHARE=1: three updates taken,taken,not-taken, all upd_ghr=0 -> ghr=4'b0110.
//    Lookup pc=0x0002 reads ctr[1^6=7]; update with upd_ghr=6 trains ctr[7].
//  5 Same-cycle update and lookup of 0x0006 (ctr=1->2) -> that cycle pred_taken=0, next cycle 1.
//  6 enable=0 with upd_valid=1 -> no state change, outputs 0.
//    rst asserted concurrently with upd_valid -> reset state.
//    PERF_W=2: 5 mispredicts -> perf_mispred=3.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: PC slicing into table index / BTB tag
// and the saturating direction-counter step.
package bp_pkg;

  // Instructions are at least 2-byte aligned, so PC bit 0 carries no information.
  localparam int unsigned PC_ALIGN_LSB = 1;

  function automatic logic [31:0] b_idx_of(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> PC_ALIGN_LSB) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc, input int unsigned idx_w,
                                         input int unsigned tag_w);
    return (pc >> (idx_w + PC_ALIGN_LSB)) & ((32'd1 << tag_w) - 32'd1);
  endfunction

  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr, input logic taken,
                                               input int unsigned ctr_w);
    logic [31:0] max_v;
    max_v = (32'd1 << ctr_w) - 32'd1;
    if (taken) return (ctr == max_v) ? ctr : ctr + 32'd1;
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_tagged_branch_predictor_if.sv
// Fetch lookup, decode resolution and performance-counter signals of the predictor.
interface gshare_tagged_branch_predictor_if #(
  parameter int ADDR_W = 16,
  parameter int GHR_W  = 4,
  parameter int PERF_W = 16
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              pred_btb_hit;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [PERF_W-1:0] perf_branches;
  logic [PERF_W-1:0] perf_mispred;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, pred_btb_hit, pred_ghr, perf_branches, perf_mispred
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_ghr, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, pred_btb_hit, pred_ghr, perf_branches, perf_mispred
  );
endinterface

// File: rtl/bp_perf_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module bp_perf_counter #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + PERF_W'(1);
    end
  end
endmodule

// File: rtl/gshare_tagged_branch_predictor.sv
// IF-stage branch predictor: bimodal/gshare saturating-counter direction table,
// tagged BTB for targets, non-speculative global history and perf counters.
module gshare_tagged_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 16,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 4,
  parameter int GSHARE  = 1,
  parameter int TAG_W   = 4,
  parameter int PERF_W  = 16
) (
  input logic clk,
  input logic rst,
  input logic enable,
  gshare_tagged_branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
  } btb_entry_t;

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  btb_entry_t       btb_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_next;

  logic [IDX_W-1:0] b_idx, l_idx, ub_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             live, upd_en, btb_hit;

  assign live   = enable & ~rst;
  assign upd_en = enable & bp.upd_valid;

  assign b_idx  = IDX_W'(b_idx_of(32'(bp.fetch_pc), IDX_W));
  assign ub_idx = IDX_W'(b_idx_of(32'(bp.upd_pc), IDX_W));
  assign f_tag  = TAG_W'(tag_of(32'(bp.fetch_pc), IDX_W, TAG_W));
  assign u_tag  = TAG_W'(tag_of(32'(bp.upd_pc), IDX_W, TAG_W));

  // The BTB is always indexed by PC alone; only the direction table is hashed.
  assign l_idx = (GSHARE != 0) ? (b_idx ^ IDX_W'(ghr_q)) : b_idx;
  assign u_idx = (GSHARE != 0) ? (ub_idx ^ IDX_W'(bp.upd_ghr)) : ub_idx;

  assign btb_hit         = live & btb_q[b_idx].valid & (btb_q[b_idx].tag == f_tag);
  assign bp.pred_btb_hit = btb_hit;
  assign bp.pred_taken   = btb_hit & ctr_q[l_idx][CTR_W-1];
  assign bp.pred_target  = bp.pred_taken ? btb_q[b_idx].target : '0;
  assign bp.pred_ghr     = live ? ghr_q : '0;

  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_next = bp.upd_taken;
    end else begin : g_ghrn
      assign ghr_next = {ghr_q[GHR_W-2:0], bp.upd_taken};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WNT;
        btb_q[i] <= '0;
      end
      ghr_q <= '0;
    end else if (upd_en) begin
      ctr_q[u_idx] <= CTR_W'(sat_ctr_next(32'(ctr_q[u_idx]), bp.upd_taken, CTR_W));
      if (bp.upd_taken) begin
        btb_q[ub_idx] <= '{valid: 1'b1, tag: u_tag, target: bp.upd_target};
      end
      ghr_q <= ghr_next;
    end
  end

  bp_perf_counter #(.PERF_W(PERF_W)) u_perf_branches (
    .clk   (clk),
    .rst   (rst),
    .inc   (upd_en),
    .count (bp.perf_branches)
  );

  bp_perf_counter #(.PERF_W(PERF_W)) u_perf_mispred (
    .clk   (clk),
    .rst   (rst),
    .inc   (upd_en & bp.upd_mispredict),
    .count (bp.perf_mispred)
  );
endmodule

// File: tb/tb_gshare_tagged_branch_predictor.sv
// Directed bench: a bimodal (16-bit perf) and a gshare (2-bit perf) instance share
// stimulus; an array-based reference model is compared against both every cycle.
module tb_gshare_tagged_branch_predictor;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [15:0] fetch_pc, upd_pc, upd_target;
  logic [3:0]  upd_ghr;
  logic        upd_valid, upd_taken, upd_mispredict;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  gshare_tagged_branch_predictor_if #(.ADDR_W(16), .GHR_W(4), .PERF_W(16)) if0 ();
  gshare_tagged_branch_predictor_if #(.ADDR_W(16), .GHR_W(4), .PERF_W(2))  if1 ();

  assign if0.fetch_pc = fetch_pc;         assign if1.fetch_pc = fetch_pc;
  assign if0.upd_valid = upd_valid;       assign if1.upd_valid = upd_valid;
  assign if0.upd_pc = upd_pc;             assign if1.upd_pc = upd_pc;
  assign if0.upd_ghr = upd_ghr;           assign if1.upd_ghr = upd_ghr;
  assign if0.upd_taken = upd_taken;       assign if1.upd_taken = upd_taken;
  assign if0.upd_target = upd_target;     assign if1.upd_target = upd_target;
  assign if0.upd_mispredict = upd_mispredict;
  assign if1.upd_mispredict = upd_mispredict;

  gshare_tagged_branch_predictor #(.GSHARE(0), .PERF_W(16)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .bp(if0));
  gshare_tagged_branch_predictor #(.GSHARE(1), .PERF_W(2)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .bp(if1));

  always #5 clk = ~clk;

  // Reference model, index g: 0 = bimodal instance, 1 = gshare instance.
  int m_ctr [2][16];
  bit m_val [2][16];
  int m_tag [2][16];
  int m_tgt [2][16];
  int m_ghr [2];
  int m_br  [2];
  int m_mp  [2];

  function automatic int perf_max(int g);
    return (g == 1) ? 3 : 65535;
  endfunction

  function automatic int dir_idx(int g, int pc, int ghr);
    int b;
    b = (pc / 2) % 16;
    return (g == 1) ? (b ^ ghr) : b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_ctr[g][i] = 1; m_val[g][i] = 0; m_tag[g][i] = 0; m_tgt[g][i] = 0;
        end
        m_ghr[g] = 0; m_br[g] = 0; m_mp[g] = 0;
      end else if (enable && upd_valid) begin
        int u, b;
        u = dir_idx(g, int'(upd_pc), int'(upd_ghr));
        if (upd_taken) m_ctr[g][u] = (m_ctr[g][u] == 3) ? 3 : m_ctr[g][u] + 1;
        else           m_ctr[g][u] = (m_ctr[g][u] == 0) ? 0 : m_ctr[g][u] - 1;
        if (upd_taken) begin
          b = (int'(upd_pc) / 2) % 16;
          m_val[g][b] = 1;
          m_tag[g][b] = (int'(upd_pc) / 32) % 16;
          m_tgt[g][b] = int'(upd_target);
        end
        m_ghr[g] = (m_ghr[g] * 2 + int'(upd_taken)) % 16;
        if (m_br[g] < perf_max(g)) m_br[g]++;
        if (upd_mispredict && m_mp[g] < perf_max(g)) m_mp[g]++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < 2; g++) begin
        bit live, hit, tk;
        int pc, b, l, tgt;
        live = !rst && enable;
        pc   = int'(fetch_pc);
        b    = (pc / 2) % 16;
        l    = dir_idx(g, pc, m_ghr[g]);
        hit  = live && m_val[g][b] && (m_tag[g][b] == (pc / 32) % 16);
        tk   = hit && (m_ctr[g][l] >= 2);
        tgt  = tk ? m_tgt[g][b] : 0;
        if (g == 0) begin
          check("cyc0_hit", 32'(if0.pred_btb_hit), 32'(hit));
          check("cyc0_taken", 32'(if0.pred_taken), 32'(tk));
          check("cyc0_target", 32'(if0.pred_target), 32'(tgt));
          check("cyc0_ghr", 32'(if0.pred_ghr), live ? 32'(m_ghr[0]) : 32'd0);
          check("cyc0_perf_br", 32'(if0.perf_branches), 32'(m_br[0]));
          check("cyc0_perf_mp", 32'(if0.perf_mispred), 32'(m_mp[0]));
        end else begin
          check("cyc1_hit", 32'(if1.pred_btb_hit), 32'(hit));
          check("cyc1_taken", 32'(if1.pred_taken), 32'(tk));
          check("cyc1_target", 32'(if1.pred_target), 32'(tgt));
          check("cyc1_ghr", 32'(if1.pred_ghr), live ? 32'(m_ghr[1]) : 32'd0);
          check("cyc1_perf_br", 32'(if1.perf_branches), 32'(m_br[1]));
          check("cyc1_perf_mp", 32'(if1.perf_mispred), 32'(m_mp[1]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic [3:0] gh, input logic mp);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_ghr = gh; upd_mispredict = mp;
    step();
    upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; fetch_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_ghr = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    step(); step();
    armed = 1'b1;
    rst = 1'b0;

    // Reset state
    fetch_pc = 16'h0004; #1;
    check("t1_taken", 32'(if0.pred_taken), 32'd0);
    check("t1_target", 32'(if0.pred_target), 32'd0);
    check("t1_hit", 32'(if0.pred_btb_hit), 32'd0);
    check("t1_perf_br", 32'(if0.perf_branches), 32'd0);
    check("t1_perf_mp", 32'(if0.perf_mispred), 32'd0);
    check("t1_model_ctr", 32'(m_ctr[0][3]), 32'd1);
    step();

    // Bimodal training and hysteresis
    upd(16'h0006, 1'b1, 16'h0040, 4'h0, 1'b1);
    upd(16'h0006, 1'b1, 16'h0040, 4'h0, 1'b0);
    fetch_pc = 16'h0006; #1;
    check("t2_model_ctr", 32'(m_ctr[0][3]), 32'd3);
    check("t2_taken", 32'(if0.pred_taken), 32'd1);
    check("t2_target", 32'(if0.pred_target), 32'h40);
    check("t2_hit", 32'(if0.pred_btb_hit), 32'd1);
    upd(16'h0006, 1'b0, 16'h0000, 4'h0, 1'b1);
    #1;
    check("t2_nt_taken", 32'(if0.pred_taken), 32'd1);

    // BTB alias replacement
    upd(16'h0026, 1'b1, 16'h0080, 4'h0, 1'b0);
    fetch_pc = 16'h0006; #1;
    check("t3_old_hit", 32'(if0.pred_btb_hit), 32'd0);
    check("t3_old_taken", 32'(if0.pred_taken), 32'd0);
    fetch_pc = 16'h0026; #1;
    check("t3_new_hit", 32'(if0.pred_btb_hit), 32'd1);
    check("t3_new_target", 32'(if0.pred_target), 32'h80);

    // Gshare history and hashed training
    rst = 1'b1; step(); rst = 1'b0;
    upd(16'h0010, 1'b1, 16'h0000, 4'h0, 1'b0);
    upd(16'h0010, 1'b1, 16'h0000, 4'h0, 1'b0);
    upd(16'h0010, 1'b0, 16'h0000, 4'h0, 1'b0);
    fetch_pc = 16'h0002; #1;
    check("t4_ghr", 32'(if1.pred_ghr), 32'h6);
    check("t4_pre_hit", 32'(if1.pred_btb_hit), 32'd0);
    upd(16'h0002, 1'b1, 16'h0050, 4'h6, 1'b0);
    check("t4_model_ctr7", 32'(m_ctr[1][7]), 32'd2);
    upd(16'h0010, 1'b1, 16'h0000, 4'h0, 1'b0);
    upd(16'h0010, 1'b0, 16'h0000, 4'h0, 1'b0);
    #1;
    check("t4_ghr_again", 32'(if1.pred_ghr), 32'h6);
    check("t4_gs_taken", 32'(if1.pred_taken), 32'd1);
    check("t4_gs_target", 32'(if1.pred_target), 32'h50);

    // Same-cycle lookup sees the pre-update counter
    rst = 1'b1; step(); rst = 1'b0;
    upd(16'h0006, 1'b1, 16'h0040, 4'h0, 1'b0);
    upd(16'h0006, 1'b0, 16'h0000, 4'h0, 1'b0);
    fetch_pc = 16'h0006;
    upd_valid = 1'b1; upd_pc = 16'h0006; upd_taken = 1'b1; upd_target = 16'h0040;
    upd_ghr = 4'h0; upd_mispredict = 1'b0;
    #1;
    check("t5_same_taken", 32'(if0.pred_taken), 32'd0);
    check("t5_same_hit", 32'(if0.pred_btb_hit), 32'd1);
    step();
    upd_valid = 1'b0; #1;
    check("t5_next_taken", 32'(if0.pred_taken), 32'd1);

    // Disable holds state and blanks lookup outputs
    enable = 1'b0;
    upd_valid = 1'b1; upd_pc = 16'h0006; upd_taken = 1'b0; upd_mispredict = 1'b1;
    #1;
    check("t6_dis_taken", 32'(if0.pred_taken), 32'd0);
    check("t6_dis_hit", 32'(if0.pred_btb_hit), 32'd0);
    check("t6_dis_ghr", 32'(if0.pred_ghr), 32'd0);
    step(); step();
    upd_valid = 1'b0; enable = 1'b1; #1;
    check("t6_hold_br", 32'(if0.perf_branches), 32'd3);
    check("t6_hold_mp", 32'(if0.perf_mispred), 32'd0);
    check("t6_hold_taken", 32'(if0.pred_taken), 32'd1);
    check("t6_hold_ghr", 32'(if0.pred_ghr), 32'h5);

    // Reset beats a same-cycle update
    rst = 1'b1;
    upd_valid = 1'b1; upd_pc = 16'h0006; upd_taken = 1'b1; upd_target = 16'h0040;
    upd_mispredict = 1'b1;
    step();
    rst = 1'b0; upd_valid = 1'b0; #1;
    check("t6_rst_hit", 32'(if0.pred_btb_hit), 32'd0);
    check("t6_rst_br", 32'(if0.perf_branches), 32'd0);
    check("t6_rst_ghr", 32'(if0.pred_ghr), 32'd0);

    // Perf counter saturation on the narrow instance
    for (int i = 0; i < 5; i++) upd(16'h0010, 1'b0, 16'h0000, 4'h0, 1'b1);
    #1;
    check("t6_sat_mp", 32'(if1.perf_mispred), 32'd3);
    check("t6_sat_br", 32'(if1.perf_branches), 32'd3);
    check("t6_wide_mp", 32'(if0.perf_mispred), 32'd5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
